// File: rtl/dipsw_debouncer.sv
// DIP switch conditioner: 2-flop synchroniser, divided sample tick, per-bit run-length debounce.
// Define DIPSW_EDGE_EVENT_EN to build the sw_rise/sw_fall/sw_changed event logic; otherwise they read 0.
module dipsw_debouncer #(
    parameter int WIDTH          = 8,
    parameter int CLK_HZ         = 27000000,
    parameter int SAMPLE_HZ      = 1000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_valid,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             sample_tick
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(STABLE_SAMPLES + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [DW-1:0]            div_cnt_q;
    logic                     tick_q;
    logic                     tick_now;
    logic [CW-1:0]            init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         stable_q, stable_d;
    logic                     valid_q, valid_d;

    // State updates land on the same edge that raises sample_tick, so they appear in the tick cycle.
    assign tick_now = (div_cnt_q == DW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            div_cnt_q <= tick_now ? '0 : div_cnt_q + 1'b1;
            tick_q    <= tick_now;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        valid_d    = valid_q;
        case (state_q)
            ST_INIT: begin
                if (tick_now) begin
                    if (init_cnt_q == CW'(STABLE_SAMPLES - 1)) begin
                        stable_d   = sync2_q;
                        valid_d    = 1'b1;
                        init_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (tick_now) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2_q[i] == stable_q[i]) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] == CW'(STABLE_SAMPLES - 1)) begin
                            stable_d[i] = ~stable_q[i];
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            valid_q    <= valid_d;
        end
    end

    assign sw_stable   = stable_q;
    assign sw_valid    = valid_q;
    assign sample_tick = tick_q;

`ifdef DIPSW_EDGE_EVENT_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q;

    // Only RUN-state toggles count as events; the INIT load never differs in state_q==ST_RUN terms.
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        if (state_q == ST_RUN) begin
            rise_d = (stable_d & ~stable_q);
            fall_d = (~stable_d & stable_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
        end
    end

    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;
`else
    assign sw_rise    = '0;
    assign sw_fall    = '0;
    assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_dipsw_debouncer.sv
// Directed bench for dipsw_debouncer at DIV=10, STABLE_SAMPLES=4; event expectations follow DIPSW_EDGE_EVENT_EN.
module tb_dipsw_debouncer;

`ifdef DIPSW_EDGE_EVENT_EN
    localparam int EV = 1;
`else
    localparam int EV = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] sw_raw;
    logic [7:0] sw_stable;
    logic       sw_valid;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       sw_changed;
    logic       sample_tick;

    int total;
    int bad;

    // window statistics
    int         lat;
    int         rise_cyc;
    int         fall_cyc;
    int         chg_cyc;
    logic [7:0] rise_acc;
    logic [7:0] fall_acc;

    dipsw_debouncer #(
        .WIDTH(8),
        .CLK_HZ(1000),
        .SAMPLE_HZ(100),
        .STABLE_SAMPLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .sw_stable(sw_stable),
        .sw_valid(sw_valid),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed),
        .sample_tick(sample_tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs n cycles sampling #1 after each edge; records first stable change and event activity.
    task automatic window(input int n);
        logic [7:0] start;
        start    = sw_stable;
        lat      = 0;
        rise_cyc = 0;
        fall_cyc = 0;
        chg_cyc  = 0;
        rise_acc = '0;
        fall_acc = '0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && sw_stable != start) lat = c;
            if (sw_rise != 0) rise_cyc++;
            if (sw_fall != 0) fall_cyc++;
            if (sw_changed) chg_cyc++;
            rise_acc = rise_acc | sw_rise;
            fall_acc = fall_acc | sw_fall;
        end
    endtask

    // Called just after reset release at a negedge; expects valid on edge 40.
    task automatic acquire(input string tag, input logic [7:0] exp);
        int ev_cyc;
        ev_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (sw_rise != 0 || sw_fall != 0 || sw_changed) ev_cyc++;
            if (c == 9)  check({tag, "_tick_early"}, 32'(sample_tick), 32'd0);
            if (c == 10) check({tag, "_first_tick"}, 32'(sample_tick), 32'd1);
            if (c == 39) check({tag, "_valid_early"}, 32'(sw_valid), 32'd0);
        end
        check({tag, "_valid"}, 32'(sw_valid), 32'd1);
        check({tag, "_tick_at_valid"}, 32'(sample_tick), 32'd1);
        check({tag, "_stable"}, 32'(sw_stable), 32'(exp));
        check({tag, "_no_events"}, 32'(ev_cyc), 32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        sw_raw = 8'hA5;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_stable", 32'(sw_stable), 32'h0);
        check("rst_valid", 32'(sw_valid), 32'h0);
        check("rst_events", 32'({sw_rise, sw_fall, sw_changed}), 32'h0);
        check("rst_tick", 32'(sample_tick), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        acquire("acq", 8'hA5);

        // clean change: bit0 1->0, accepted 40 cycles later
        sw_raw = 8'hA4;
        window(60);
        check("clean_stable", 32'(sw_stable), 32'hA4);
        check("clean_latency", 32'(lat), 32'd40);
        check("clean_fall_val", 32'(fall_acc), EV ? 32'h01 : 32'h00);
        check("clean_fall_cyc", 32'(fall_cyc), 32'(EV));
        check("clean_chg_cyc", 32'(chg_cyc), 32'(EV));
        check("clean_rise", 32'(rise_acc), 32'h00);

        // bounce: bit3 held opposite for 3 ticks only
        sw_raw = 8'hAC;
        window(30);
        sw_raw = 8'hA4;
        window(30);
        check("bounce_stable", 32'(sw_stable), 32'hA4);
        check("bounce_events", 32'(rise_cyc + fall_cyc + chg_cyc), 32'd0);

        // simultaneous: bit7 1->0, bit1 0->1
        sw_raw = 8'h26;
        window(60);
        check("simul_stable", 32'(sw_stable), 32'h26);
        check("simul_latency", 32'(lat), 32'd40);
        check("simul_rise_val", 32'(rise_acc), EV ? 32'h02 : 32'h00);
        check("simul_fall_val", 32'(fall_acc), EV ? 32'h80 : 32'h00);
        check("simul_rise_cyc", 32'(rise_cyc), 32'(EV));
        check("simul_fall_cyc", 32'(fall_cyc), 32'(EV));
        check("simul_chg_cyc", 32'(chg_cyc), 32'(EV));

        // reset mid-run: bit2 pending with two agreeing samples counted
        sw_raw = 8'h22;
        window(20);
        check("mid_pre_stable", 32'(sw_stable), 32'h26);
        check("mid_pre_valid", 32'(sw_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_stable", 32'(sw_stable), 32'h0);
        check("mid_rst_valid", 32'(sw_valid), 32'h0);
        check("mid_rst_tick", 32'(sample_tick), 32'h0);
        check("mid_rst_events", 32'({sw_rise, sw_fall, sw_changed}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acquire("reacq", 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
